// File: rtl/frame_downloader_pkg.sv
// Shared types, command codes and PSRAM timing helpers for the frame
// uploader/downloader pair.
package frame_downloader_pkg;

    typedef logic [3:0] t_state;

    localparam t_state IDLE             = 4'd0;
    localparam t_state PUSH_FRAME_START = 4'd1;
    localparam t_state WAIT_BUFFER      = 4'd2;
    localparam t_state READ_REQ         = 4'd3;
    localparam t_state READ_DATA        = 4'd4;
    localparam t_state GAP              = 4'd5;
    localparam t_state PUSH_ROW_READY   = 4'd6;
    localparam t_state PUSH_FRAME_END   = 4'd7;
    localparam t_state DONE             = 4'd8;

    localparam logic [1:0] CMD_FRAME_START = 2'd1;
    localparam logic [1:0] CMD_ROW         = 2'd2;
    localparam logic [1:0] CMD_FRAME_END   = 2'd3;

    // Idle cycles the PSRAM controller needs between two burst commands.
    function automatic int burst_delay(input int burst_bytes);
        return (burst_bytes / 8 < 1) ? 1 : burst_bytes / 8;
    endfunction

endpackage

// File: rtl/frame_downloader_read_burst.sv
// Burst-read handshake: holds read_rq/read_addr, counts the words of the
// granted burst and times the mandatory idle gap after it.
module psram_read_burst
    import frame_downloader_pkg::*;
#(
    parameter int BURST_WORDS = 8,
    parameter int TCMD        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        burst_go_i,
    input  logic [20:0] addr_i,
    input  logic        read_ack_i,
    input  logic        read_data_valid_i,
    output logic        read_rq_o,
    output logic [20:0] read_addr_o,
    output logic        word_valid_o,
    output logic        burst_done_o,
    output logic        gap_done_o
);

    localparam int CNT_W = $clog2(BURST_WORDS + 1);
    localparam int GAP_W = (TCMD < 1) ? 1 : $clog2(TCMD + 1);

    logic             rq_q, rq_d;
    logic [20:0]      addr_q, addr_d;
    logic             acked_q, acked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    // Data words only count once the grant has been registered.
    assign word_valid_o = acked_q & read_data_valid_i;
    assign burst_done_o = word_valid_o && (cnt_q == CNT_W'(BURST_WORDS - 1));
    assign gap_done_o   = (gap_q == GAP_W'(TCMD));
    assign read_rq_o    = rq_q;
    assign read_addr_o  = addr_q;

    always_comb begin
        rq_d    = rq_q;
        addr_d  = addr_q;
        acked_d = acked_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        if (burst_go_i) begin
            rq_d    = 1'b1;
            addr_d  = addr_i;
            acked_d = 1'b0;
            cnt_d   = '0;
        end
        if (rq_q && !acked_q && read_ack_i) begin
            acked_d = 1'b1;
            cnt_d   = '0;
        end
        if (word_valid_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Gap counter saturates so the frame FSM may linger waiting for ack low.
        if (burst_done_o) begin
            rq_d    = 1'b0;
            acked_d = 1'b0;
            cnt_d   = '0;
            gap_d   = '0;
        end else if (!gap_done_o) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rq_q    <= 1'b0;
            addr_q  <= '0;
            acked_q <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            rq_q    <= rq_d;
            addr_q  <= addr_d;
            acked_q <= acked_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/frame_downloader.sv
// Streams a stored RGB565 frame out of PSRAM row by row into a 32-bit row
// buffer, announcing frame start, row ready and frame end on a command queue.
module frame_downloader
    import frame_downloader_pkg::*;
#(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int TCMD         = burst_delay(MEMORY_BURST)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] base_addr,
    output logic        read_rq,
    output logic [20:0] read_addr,
    input  logic        read_ack,
    input  logic        read_data_valid,
    input  logic [31:0] read_data,
    output logic        line_wr_en,
    output logic [9:0]  line_wr_addr,
    output logic [31:0] line_wr_data,
    input  logic        buffer_free,
    output logic        cmd_wr_en,
    output logic [1:0]  cmd_data,
    input  logic        cmd_full,
    output logic        download_done
);

    localparam int BURST_WORDS = MEMORY_BURST / 4;
    localparam int ROW_WORDS   = FRAME_WIDTH / 2;
    localparam int ROW_W       = $clog2(FRAME_HEIGHT + 1);

    if ((FRAME_WIDTH % (MEMORY_BURST / 2)) != 0) begin : g_width_check
        $error("FRAME_WIDTH must be a multiple of MEMORY_BURST/2");
    end

    t_state           state_q, state_d;
    logic [20:0]      frame_addr_q, frame_addr_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [9:0]       word_q, word_d;
    logic             cmd_wr_en_q, cmd_wr_en_d;
    logic [1:0]       cmd_data_q, cmd_data_d;
    logic             line_wr_en_q;
    logic [9:0]       line_wr_addr_q;
    logic [31:0]      line_wr_data_q;
    logic             download_done_q;

    logic burst_go;
    logic word_valid;
    logic burst_done;
    logic gap_done;

    psram_read_burst #(
        .BURST_WORDS (BURST_WORDS),
        .TCMD        (TCMD)
    ) u_burst (
        .clk               (clk),
        .reset             (reset),
        .burst_go_i        (burst_go),
        .addr_i            (frame_addr_q),
        .read_ack_i        (read_ack),
        .read_data_valid_i (read_data_valid),
        .read_rq_o         (read_rq),
        .read_addr_o       (read_addr),
        .word_valid_o      (word_valid),
        .burst_done_o      (burst_done),
        .gap_done_o        (gap_done)
    );

    always_comb begin
        state_d      = state_q;
        frame_addr_d = frame_addr_q;
        row_d        = row_q;
        word_d       = word_q;
        burst_go     = 1'b0;
        cmd_wr_en_d  = 1'b0;
        cmd_data_d   = 2'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_addr_d = base_addr;
                    row_d        = '0;
                    state_d      = PUSH_FRAME_START;
                end
            end
            PUSH_FRAME_START: begin
                if (!cmd_full) begin
                    cmd_wr_en_d = 1'b1;
                    cmd_data_d  = CMD_FRAME_START;
                    state_d     = WAIT_BUFFER;
                end
            end
            WAIT_BUFFER: begin
                if (buffer_free) begin
                    word_d   = '0;
                    burst_go = 1'b1;
                    state_d  = READ_REQ;
                end
            end
            READ_REQ: begin
                if (read_ack) begin
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                if (word_valid) begin
                    word_d = word_q + 1'b1;
                end
                // Address is in 16-bit units, so one 32-byte burst steps by 16.
                if (burst_done) begin
                    frame_addr_d = frame_addr_q + 21'd16;
                    state_d      = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (word_q == 10'(ROW_WORDS)) begin
                        state_d = PUSH_ROW_READY;
                    end else if (!read_ack) begin
                        burst_go = 1'b1;
                        state_d  = READ_REQ;
                    end
                end
            end
            PUSH_ROW_READY: begin
                if (!cmd_full) begin
                    cmd_wr_en_d = 1'b1;
                    cmd_data_d  = CMD_ROW;
                    row_d       = row_q + 1'b1;
                    state_d     = (row_d == ROW_W'(FRAME_HEIGHT)) ? PUSH_FRAME_END : WAIT_BUFFER;
                end
            end
            PUSH_FRAME_END: begin
                if (!cmd_full) begin
                    cmd_wr_en_d = 1'b1;
                    cmd_data_d  = CMD_FRAME_END;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            frame_addr_q    <= '0;
            row_q           <= '0;
            word_q          <= '0;
            cmd_wr_en_q     <= 1'b0;
            cmd_data_q      <= 2'd0;
            line_wr_en_q    <= 1'b0;
            line_wr_addr_q  <= '0;
            line_wr_data_q  <= '0;
            download_done_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_addr_q    <= frame_addr_d;
            row_q           <= row_d;
            word_q          <= word_d;
            cmd_wr_en_q     <= cmd_wr_en_d;
            cmd_data_q      <= cmd_data_d;
            line_wr_en_q    <= word_valid;
            download_done_q <= (state_d == DONE);
            if (word_valid) begin
                line_wr_addr_q <= word_q;
                line_wr_data_q <= read_data;
            end
        end
    end

    assign cmd_wr_en     = cmd_wr_en_q;
    assign cmd_data      = cmd_data_q;
    assign line_wr_en    = line_wr_en_q;
    assign line_wr_addr  = line_wr_addr_q;
    assign line_wr_data  = line_wr_data_q;
    assign download_done = download_done_q;

endmodule
